// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_arbiter : round-robin arbiter of NUM_CH requesters onto one memory port |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module mem_arbiter #(
    parameter int NUM_CH  = 2,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          ch_read,
    input  logic [NUM_CH-1:0]          ch_write,
    input  logic [NUM_CH*DATA_W/8-1:0] ch_wmask,
    input  logic [NUM_CH*DATA_W-1:0]   ch_address,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
    output logic [NUM_CH-1:0]          ch_resp,
    output logic [NUM_CH*DATA_W-1:0]   ch_rdata,
    output logic                       mem_read,
    output logic                       mem_write,
    output logic [DATA_W/8-1:0]        mem_byte_enable,
    output logic [DATA_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic                       mem_resp,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       timeout_err
);

    localparam int IDX_W = $clog2(NUM_CH);
    localparam int BE_W  = DATA_W / 8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_last;
    logic [DATA_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [BE_W-1:0]    r_byte_enable;
    logic               r_mem_read;
    logic               r_mem_write;

    logic [NUM_CH-1:0]  w_req;
    logic               w_found;
    logic [IDX_W-1:0]   w_grant;
    logic               w_sel_write;
    logic [DATA_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic [BE_W-1:0]    w_sel_wmask;
    logic               w_timeout;

    assign w_req = ch_read | ch_write;

    // Descending offset so the channel closest after r_last is assigned last and wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (w_req[j] && (((int'(r_last) + i) % NUM_CH) == j)) begin
                    w_found = 1'b1;
                    w_grant = IDX_W'(j);
                end
            end
        end
    end

    always_comb begin
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wmask = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if (w_grant == IDX_W'(j)) begin
                w_sel_write = ch_write[j];
                w_sel_addr  = ch_address[j*DATA_W +: DATA_W];
                w_sel_wdata = ch_wdata[j*DATA_W +: DATA_W];
                w_sel_wmask = ch_wmask[j*BE_W +: BE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_last        <= IDX_W'(NUM_CH - 1);
            r_addr        <= '0;
            r_wdata       <= '0;
            r_byte_enable <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state       <= S_BUSY;
                        r_grant       <= w_grant;
                        r_last        <= w_grant;
                        r_addr        <= w_sel_addr;
                        r_wdata       <= w_sel_wdata;
                        r_byte_enable <= w_sel_write ? w_sel_wmask : {BE_W{1'b1}};
                        r_mem_write   <= w_sel_write;
                        r_mem_read    <= ~w_sel_write;
                    end
                end
                S_BUSY: begin
                    if (mem_resp || w_timeout) begin
                        r_state     <= S_IDLE;
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            localparam int CNT_W = $clog2(TIMEOUT + 1);
            logic [CNT_W-1:0] r_cnt;

            // Held at zero while idle, so it starts from zero on every BUSY entry.
            always_ff @(posedge clk) begin
                if (rst || (r_state == S_IDLE)) begin
                    r_cnt <= '0;
                end else if (!mem_resp) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign w_timeout   = (r_state == S_BUSY) && !mem_resp && (r_cnt == CNT_W'(TIMEOUT));
            assign timeout_err = w_timeout & ~rst;
        end else begin : g_no_timeout
            assign w_timeout   = 1'b0;
            assign timeout_err = 1'b0;
        end
    endgenerate

    always_comb begin
        ch_resp  = '0;
        ch_rdata = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            if ((r_state == S_BUSY) && mem_resp && !rst && (r_grant == IDX_W'(j))) begin
                ch_resp[j]                    = 1'b1;
                ch_rdata[j*DATA_W +: DATA_W]  = mem_rdata;
            end
        end
    end

    assign mem_read        = r_mem_read & ~rst;
    assign mem_write       = r_mem_write & ~rst;
    assign mem_byte_enable = r_byte_enable;
    assign mem_address     = r_addr;
    assign mem_wdata       = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_arbiter : directed and random checks of mem_arbiter (4 ch, TO=5)     |
// | Revision       : 1.0                                                       |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int BW = DW / 8;
    localparam int TO = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    ch_read, ch_write, ch_resp;
    logic [N*BW-1:0] ch_wmask;
    logic [N*DW-1:0] ch_address, ch_wdata, ch_rdata;
    logic            mem_read, mem_write, mem_resp, timeout_err;
    logic [BW-1:0]   mem_byte_enable;
    logic [DW-1:0]   mem_address, mem_wdata, mem_rdata;

    mem_arbiter #(.NUM_CH(N), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ch_read(ch_read), .ch_write(ch_write), .ch_wmask(ch_wmask),
        .ch_address(ch_address), .ch_wdata(ch_wdata),
        .ch_resp(ch_resp), .ch_rdata(ch_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester state: a request is held from arming until its completion.
    bit            p_act [N];
    bit            p_rd  [N];
    bit            p_wr  [N];
    logic [DW-1:0] p_addr [N];
    logic [DW-1:0] p_wdata[N];
    logic [BW-1:0] p_mask [N];

    bit scramble, drop_req, idle_noise, hold_all, rnd_mode;
    int resp_lat;

    // Reference: one transaction in flight, round-robin pointer, memory image.
    bit            m_busy;
    int            m_grant, m_last, m_cnt;
    bit            m_wr;
    logic [DW-1:0] m_addr, m_wdata;
    logic [BW-1:0] m_be;
    logic [DW-1:0] phys     [16];
    logic [DW-1:0] model_mem[16];

    int rd_cycles, wr_cycles, to_cnt, cyc, busy_at, to_delay;
    int resp_cnt[N];
    int grant_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [BW-1:0] be);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    task automatic clr_stats();
        rd_cycles = 0; wr_cycles = 0; to_cnt = 0; to_delay = -1;
        for (int i = 0; i < N; i++) resp_cnt[i] = 0;
        grant_q.delete();
    endtask

    task automatic arm(input int c, input bit rd, input bit wr, input logic [DW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] m);
        p_act[c] = 1'b1; p_rd[c] = rd; p_wr[c] = wr;
        p_addr[c] = a; p_wdata[c] = d; p_mask[c] = m;
    endtask

    task automatic cycle(input bit rst_in);
        bit            resp_now, to_now, found;
        logic [N-1:0]  exp_resp;
        logic [N*DW-1:0] exp_rdata;
        int            c;
        if (rnd_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!p_act[i] && $urandom_range(0, 3) == 0) begin
                    p_wr[i] = 1'($urandom_range(0, 1));
                    arm(i, p_wr[i] ? 1'($urandom_range(0, 1)) : 1'b1, p_wr[i],
                        DW'($urandom), DW'($urandom), BW'($urandom));
                end
            end
        end
        rst = rst_in;
        for (int i = 0; i < N; i++) begin
            ch_read[i]  = p_act[i] & p_rd[i];
            ch_write[i] = p_act[i] & p_wr[i];
            ch_address[i*DW +: DW] = p_addr[i];
            ch_wdata[i*DW +: DW]   = p_wdata[i];
            ch_wmask[i*BW +: BW]   = p_mask[i];
        end
        if (m_busy) begin
            if (scramble) begin
                for (int i = 0; i < N; i++) begin
                    ch_read[i]  = 1'($urandom_range(0, 1));
                    ch_write[i] = 1'($urandom_range(0, 1));
                    ch_address[i*DW +: DW] = DW'($urandom);
                    ch_wdata[i*DW +: DW]   = DW'($urandom);
                    ch_wmask[i*BW +: BW]   = BW'($urandom);
                end
            end
            if (drop_req) begin
                ch_read[m_grant]  = 1'b0;
                ch_write[m_grant] = 1'b0;
            end
        end
        resp_now = m_busy ? (resp_lat != 0 && m_cnt + 1 == resp_lat)
                          : (idle_noise && $urandom_range(0, 1) == 1);
        mem_resp  = resp_now;
        mem_rdata = resp_now ? phys[mem_address[3:0]] : DW'($urandom);
        to_now    = !rst_in && m_busy && !resp_now && m_cnt == TO;
        exp_resp  = '0;
        exp_rdata = '0;
        if (!rst_in && m_busy && resp_now) begin
            exp_resp[m_grant] = 1'b1;
            exp_rdata[m_grant*DW +: DW] = model_mem[m_addr[3:0]];
        end

        @(negedge clk);
        check("mem_read",        64'(mem_read),        64'(!rst_in && m_busy && !m_wr));
        check("mem_write",       64'(mem_write),       64'(!rst_in && m_busy && m_wr));
        check("mem_address",     64'(mem_address),     64'(m_addr));
        check("mem_wdata",       64'(mem_wdata),       64'(m_wdata));
        check("mem_byte_enable", 64'(mem_byte_enable), 64'(m_be));
        check("ch_resp",         64'(ch_resp),         64'(exp_resp));
        check("ch_rdata",        64'(ch_rdata),        64'(exp_rdata));
        check("timeout_err",     64'(timeout_err),     64'(to_now));
        if (mem_read)  rd_cycles++;
        if (mem_write) wr_cycles++;
        for (int i = 0; i < N; i++) resp_cnt[i] += int'(ch_resp[i]);
        if (timeout_err) begin
            to_cnt++;
            to_delay = cyc - busy_at;
        end
        if (resp_now && mem_write)
            phys[mem_address[3:0]] = merge(phys[mem_address[3:0]], mem_wdata, mem_byte_enable);

        @(posedge clk);
        #1;
        cyc++;
        if (rst_in) begin
            m_busy = 1'b0; m_last = N - 1; m_cnt = 0; m_wr = 1'b0;
            m_addr = '0; m_wdata = '0; m_be = '0;
        end else if (m_busy) begin
            if (resp_now) begin
                if (m_wr) model_mem[m_addr[3:0]] = merge(model_mem[m_addr[3:0]], m_wdata, m_be);
                if (!hold_all) p_act[m_grant] = 1'b0;
                m_busy = 1'b0;
            end else if (to_now) begin
                p_act[m_grant] = 1'b0;
                m_busy = 1'b0;
            end else begin
                m_cnt++;
            end
        end else begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (!found && p_act[c]) begin
                    found   = 1'b1;
                    m_busy  = 1'b1; m_grant = c; m_last = c; m_cnt = 0;
                    m_wr    = p_wr[c];
                    m_addr  = p_addr[c];
                    m_wdata = p_wdata[c];
                    m_be    = p_wr[c] ? p_mask[c] : {BW{1'b1}};
                    busy_at = cyc;
                    grant_q.push_back(c);
                    if (rnd_mode) resp_lat = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
                end
            end
        end
    endtask

    task automatic check_order(input string tag, input int exp[$]);
        check({tag, "_len"}, 64'(grant_q.size()), 64'(exp.size()));
        for (int i = 0; i < grant_q.size() && i < exp.size(); i++)
            check(tag, 64'(grant_q[i]), 64'(exp[i]));
    endtask

    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < N; i++) begin
            p_act[i] = 0; p_rd[i] = 0; p_wr[i] = 0; p_addr[i] = '0; p_wdata[i] = '0; p_mask[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            v = DW'($urandom);
            phys[i] = v; model_mem[i] = v;
        end
        scramble = 0; drop_req = 0; idle_noise = 0; hold_all = 0; rnd_mode = 0; resp_lat = 1;
        m_busy = 0; m_grant = 0; m_last = N - 1; m_cnt = 0; m_wr = 0;
        m_addr = '0; m_wdata = '0; m_be = '0; cyc = 0; busy_at = 0;
        rst = 1'b1; ch_read = '0; ch_write = '0; ch_wmask = '0; ch_address = '0; ch_wdata = '0;
        mem_resp = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        clr_stats();
        cycle(1);

        // Single read on channel 1, memory answers in the third BUSY cycle.
        phys[4] = 16'hBEEF; model_mem[4] = 16'hBEEF;
        idle_noise = 1; resp_lat = 3;
        arm(1, 1, 0, 16'h1234, 16'h0, 2'b00);
        repeat (6) cycle(0);
        check("t1_rd_cycles", 64'(rd_cycles), 64'd3);
        check("t1_resp1", 64'(resp_cnt[1]), 64'd1);
        check_order("t1_order", '{1});

        // Masked write on channel 0 with requester inputs scrambled mid-BUSY.
        clr_stats();
        phys[5] = 16'h1122; model_mem[5] = 16'h1122;
        scramble = 1;
        arm(0, 0, 1, 16'h0005, 16'hAB00, 2'b10);
        repeat (5) cycle(0);
        scramble = 0;
        check("t2_wr_cycles", 64'(wr_cycles), 64'd3);
        check("t2_rd_cycles", 64'(rd_cycles), 64'd0);
        check("t2_resp0", 64'(resp_cnt[0]), 64'd1);
        check("t2_mem5", 64'(phys[5]), 64'h0000_0000_0000_AB22);

        // Read+write collision on channel 2: write wins.
        clr_stats();
        resp_lat = 2;
        arm(2, 1, 1, 16'h0007, 16'h5A5A, 2'b11);
        repeat (4) cycle(0);
        check("t3_wr_cycles", 64'(wr_cycles), 64'd2);
        check("t3_rd_cycles", 64'(rd_cycles), 64'd0);
        check("t3_resp2", 64'(resp_cnt[2]), 64'd1);
        check("t3_mem7", 64'(phys[7]), 64'h0000_0000_0000_5A5A);

        // Fairness: all four channels requesting continuously, back-to-back grants.
        cycle(1);
        clr_stats();
        idle_noise = 0; hold_all = 1; resp_lat = 1;
        for (int i = 0; i < N; i++) arm(i, 1, 0, DW'(16'h0100 + i), 16'h0, 2'b00);
        repeat (16) cycle(0);
        hold_all = 0;
        for (int i = 0; i < N; i++) p_act[i] = 0;
        check_order("t4_order", '{0, 1, 2, 3, 0, 1, 2, 3});
        for (int i = 0; i < N; i++) check("t4_resp", 64'(resp_cnt[i]), 64'd2);
        cycle(0);

        // Timeout on channel 1, then channel 2 is served.
        clr_stats();
        resp_lat = 0;
        arm(1, 1, 0, 16'h0003, 16'h0, 2'b00);
        arm(2, 1, 0, 16'h0009, 16'h0, 2'b00);
        repeat (7) cycle(0);
        resp_lat = 2;
        repeat (4) cycle(0);
        check("t5_to_cnt", 64'(to_cnt), 64'd1);
        check("t5_to_delay", 64'(to_delay), 64'd5);
        check("t5_resp1", 64'(resp_cnt[1]), 64'd0);
        check("t5_resp2", 64'(resp_cnt[2]), 64'd1);
        check_order("t5_order", '{1, 2});

        // Reset during a read on channel 2; channel 0 must win afterwards.
        cycle(1);
        clr_stats();
        resp_lat = 0;
        arm(2, 1, 0, 16'h0002, 16'h0, 2'b00);
        cycle(0);
        arm(0, 1, 0, 16'h000A, 16'h0, 2'b00);
        arm(3, 1, 0, 16'h000B, 16'h0, 2'b00);
        cycle(0);
        cycle(1);
        p_act[2] = 0;
        resp_lat = 1;
        repeat (5) cycle(0);
        check_order("t6_order", '{2, 0, 3});
        check("t6_resp2", 64'(resp_cnt[2]), 64'd0);
        check("t6_resp0", 64'(resp_cnt[0]), 64'd1);
        check("t6_resp3", 64'(resp_cnt[3]), 64'd1);
        check("t6_to_cnt", 64'(to_cnt), 64'd0);

        // Requester drops its request mid-BUSY and is still completed.
        clr_stats();
        resp_lat = 3; drop_req = 1;
        arm(1, 1, 0, 16'h0001, 16'h0, 2'b00);
        repeat (5) cycle(0);
        drop_req = 0;
        check("t7_resp1", 64'(resp_cnt[1]), 64'd1);

        // Random traffic with random latencies, occasional timeouts and noise.
        rnd_mode = 1; scramble = 1; idle_noise = 1;
        repeat (400) cycle(0);
        rnd_mode = 0; resp_lat = 1;
        repeat (40) cycle(0);
        scramble = 0; idle_noise = 0;
        for (int i = 0; i < 16; i++) check("mem_image", 64'(phys[i]), 64'(model_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
- REQ-001 The block SHALL have parameter NUM_CH, default 2, number of requester channels (range 2..8).
- REQ-002 The block SHALL have parameter DATA_W, default 16, data and address width in bits (multiple of 8).
- REQ-003 The block SHALL have parameter TIMEOUT, default 0, maximum cycles to wait for mem_resp; 0 disables the timeout.
- REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
- REQ-005 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
- REQ-006 The block SHALL have port ch_read, input, NUM_CH, per-channel read request, held until that channel's ch_resp.
- REQ-007 The block SHALL have port ch_write, input, NUM_CH, per-channel write request, held until that channel's ch_resp.
- REQ-008 The block SHALL have port ch_wmask, input, NUM_CH x DATA_W/8, per-channel byte enables.
- REQ-009 The block SHALL have port ch_address, input, NUM_CH x DATA_W, per-channel address.
- REQ-010 The block SHALL have port ch_wdata, input, NUM_CH x DATA_W, per-channel write data.
- REQ-011 The block SHALL have port ch_resp, output, NUM_CH, per-channel completion pulse.
- REQ-012 The block SHALL have port ch_rdata, output, NUM_CH x DATA_W, per-channel read data, valid when ch_resp is high.
- REQ-013 The block SHALL have port mem_read / mem_write, output, 1 each, memory request strobes.
- REQ-014 The block SHALL have port mem_byte_enable, output, DATA_W/8, memory byte enables.
- REQ-015 The block SHALL have port mem_address / mem_wdata, output, DATA_W each, memory address and data.
- REQ-016 The block SHALL have port mem_resp, input, 1, memory completion.
- REQ-017 The block SHALL have port mem_rdata, input, DATA_W, memory read data.
- REQ-018 The block SHALL have port timeout_err, output, 1, one-cycle pulse on transaction abort.

Function
- REQ-019 The FSM SHALL have states IDLE and BUSY.
- REQ-020 In IDLE with any ch_read|ch_write bit set, the block SHALL grant one channel, latch its op, address, wdata and wmask into internal registers, and enter BUSY at the next edge.
- REQ-021 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod NUM_CH; last_grant updates on each grant; last_grant resets to NUM_CH-1 so channel 0 wins first.
- REQ-022 If a granted channel asserts both read and write, the block SHALL perform the write.
- REQ-023 In BUSY, mem_read/mem_write, mem_address, mem_wdata and mem_byte_enable SHALL be driven only from the latched registers; requester input changes during BUSY SHALL be ignored.
- REQ-024 mem_byte_enable SHALL equal the latched wmask for writes and all-ones for reads.
- REQ-025 In IDLE, mem_read and mem_write SHALL be 0.
- REQ-026 Minimum latency SHALL be: request visible in cycle t, mem strobe high in cycle t+1, and ch_resp in the same cycle as mem_resp.
- REQ-027 In BUSY with mem_resp=1, ch_resp[grant] SHALL be 1 combinationally, ch_rdata[grant] SHALL equal mem_rdata, and the FSM SHALL return to IDLE at the next edge.
- REQ-028 ch_resp bits for non-granted channels SHALL be 0, and their ch_rdata SHALL be 0.
- REQ-029 The block SHALL ignore mem_resp in IDLE.
- REQ-030 The block SHALL need no IDLE gap between back-to-back grants beyond the single IDLE cycle.
- REQ-031 A requester that drops its request mid-BUSY SHALL still have its transaction completed and receive ch_resp.
- REQ-032 When TIMEOUT>0, a counter of width clog2(TIMEOUT+1) SHALL clear on entering BUSY and increment each BUSY cycle without mem_resp.
- REQ-033 When that counter reaches TIMEOUT, the block SHALL pulse timeout_err for one cycle, assert no ch_resp, and return to IDLE; mem_resp in that same cycle SHALL take priority, giving normal completion with no error.
- REQ-034 When TIMEOUT=0, timeout_err SHALL be tied to 0.

Reset
- REQ-035 While rst=1, the state SHALL be IDLE, last_grant NUM_CH-1, latched registers 0 and the timeout counter 0.
- REQ-036 While rst=1, mem_read, mem_write, ch_resp and timeout_err SHALL be 0, and mem_byte_enable, mem_address and mem_wdata SHALL be 0 from the next cycle.
- REQ-037 If rst is asserted during BUSY, the block SHALL abandon the transaction without ch_resp, and mem strobes SHALL be 0 in the cycle after the reset edge.

Verification
- REQ-038 The bench SHALL cover a single read: ch_read[1]=1, addr 0x1234; mem_resp after 3 cycles with rdata 0xBEEF -> mem_read high 3 cycles, mem_address=0x1234, ch_resp[1] for 1 cycle with ch_rdata[1]=0xBEEF.
- REQ-039 The bench SHALL cover round-robin fairness: NUM_CH=4, all channels requesting continuously -> grant order 0,1,2,3,0 with each completing exactly once per 4 transactions.
- REQ-040 The bench SHALL cover a masked write: ch_write[0], wmask 2'b10, wdata 0xAB00 -> mem_write=1, mem_byte_enable=2'b10, mem_wdata=0xAB00, ch_read/ch_write changed mid-BUSY do not alter mem outputs.
- REQ-041 The bench SHALL cover timeout: TIMEOUT=5, mem_resp never asserted -> timeout_err pulses once 5 cycles after BUSY entry, no ch_resp, next pending channel granted.
- REQ-042 The bench SHALL cover reset mid-BUSY: rst pulsed 1 cycle during a read -> mem_read 0 the next cycle, no ch_resp, channel 0 wins the next arbitration.
- REQ-043 The bench SHALL cover a read+write collision: channel 2 asserts both -> write performed, single ch_resp[2].
